// File: rtl/vga_fb_write_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_write_arbiter
//
// Owns the single write port of the VGA frame buffer. NREQ pixel requesters
// share it through round-robin valid/ready arbitration. A built-in clear
// sequencer can take over the port and fill the whole HD x VD frame with one
// colour.
//
// Ports
//   clk            system clock
//   arst           asynchronous reset, active-high
//   req_valid_i    per-requester pixel write pending
//   req_ready_o    one-hot grant (combinational); transfer on valid & ready
//   req_x_i        packed x coordinates, requester n at [n*ADDR_BITS +: ADDR_BITS]
//   req_y_i        packed y coordinates, same packing
//   req_color_i    packed 2-bit colour codes, requester n at [n*2 +: 2]
//   clear_i        start a full-frame clear
//   clear_color_i  fill colour, sampled together with clear_i
//   busy_o         clear sequence in progress
//   err_o          one-cycle pulse: an accepted request was outside the frame
//   we_o           frame-buffer write enable
//   addr_x_o       frame-buffer x address
//   addr_y_o       frame-buffer y address
//   color_o        frame-buffer colour code
// ---------------------------------------------------------------------------
module vga_fb_write_arbiter #(
    parameter int NREQ      = 2,
    parameter int HD        = 1280,
    parameter int VD        = 1024,
    parameter int ADDR_BITS = 11
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [NREQ-1:0]           req_valid_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic [NREQ*ADDR_BITS-1:0] req_x_i,
    input  logic [NREQ*ADDR_BITS-1:0] req_y_i,
    input  logic [NREQ*2-1:0]         req_color_i,
    input  logic                      clear_i,
    input  logic [1:0]                clear_color_i,
    output logic                      busy_o,
    output logic                      err_o,
    output logic                      we_o,
    output logic [ADDR_BITS-1:0]      addr_x_o,
    output logic [ADDR_BITS-1:0]      addr_y_o,
    output logic [1:0]                color_o
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDR_BITS-1:0] X_LAST = ADDR_BITS'(HD - 1);
    localparam logic [ADDR_BITS-1:0] Y_LAST = ADDR_BITS'(VD - 1);

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t               state_q;
    logic [PTR_W-1:0]     ptr_q;
    logic                 busy_q;
    logic                 err_p1;
    logic                 vld_p1;
    logic [ADDR_BITS-1:0] addr_x_p1;
    logic [ADDR_BITS-1:0] addr_y_p1;
    logic [1:0]           color_p1;

    // Round-robin successor of requester n.
    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] n);
        if (int'(n) >= NREQ - 1)
            return '0;
        else
            return n + 1'b1;
    endfunction

    // True when the coordinate lies inside the visible frame.
    function automatic logic in_frame(input logic [ADDR_BITS-1:0] x,
                                      input logic [ADDR_BITS-1:0] y);
        return (x <= X_LAST) && (y <= Y_LAST);
    endfunction

    // ---------------------------------------------------------------
    // Stage 0: combinational arbitration and request selection
    // ---------------------------------------------------------------
    logic [NREQ-1:0]      gnt;
    logic [PTR_W-1:0]     gnt_idx;
    logic                 gnt_any;
    int                   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        // A clear request (or reset) suppresses every grant in this cycle,
        // so the clear always wins over simultaneous pixel requests.
        if (state_q == SERVE && !clear_i && !arst) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NREQ)
                    idx = idx - NREQ;
                if (!gnt_any && req_valid_i[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PTR_W'(idx);
                end
            end
            gnt[gnt_idx] = gnt_any;
        end
    end

    assign req_ready_o = gnt;

    logic [ADDR_BITS-1:0] sel_x;
    logic [ADDR_BITS-1:0] sel_y;
    logic [1:0]           sel_color;

    assign sel_x     = req_x_i[gnt_idx*ADDR_BITS +: ADDR_BITS];
    assign sel_y     = req_y_i[gnt_idx*ADDR_BITS +: ADDR_BITS];
    assign sel_color = req_color_i[gnt_idx*2 +: 2];

    // ---------------------------------------------------------------
    // Stage 1: registered frame-buffer write port and FSM
    // ---------------------------------------------------------------
    // During CLEAR the output address registers double as the x/y clear
    // counters: the pixel being presented is the counter value, and the
    // colour register keeps the latched fill colour for the whole frame.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= SERVE;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            err_p1    <= 1'b0;
            vld_p1    <= 1'b0;
            addr_x_p1 <= '0;
            addr_y_p1 <= '0;
            color_p1  <= '0;
        end else begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            case (state_q)
                SERVE: begin
                    busy_q <= 1'b0;
                    if (clear_i) begin
                        // First clear pixel is presented together with busy.
                        state_q   <= CLEAR;
                        busy_q    <= 1'b1;
                        vld_p1    <= 1'b1;
                        addr_x_p1 <= '0;
                        addr_y_p1 <= '0;
                        color_p1  <= clear_color_i;
                    end else if (gnt_any) begin
                        ptr_q <= ptr_after(gnt_idx);
                        if (in_frame(sel_x, sel_y)) begin
                            vld_p1    <= 1'b1;
                            addr_x_p1 <= sel_x;
                            addr_y_p1 <= sel_y;
                            color_p1  <= sel_color;
                        end else begin
                            // Swallow the request; addresses stay untouched.
                            err_p1 <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (addr_x_p1 == X_LAST && addr_y_p1 == Y_LAST) begin
                        // Last pixel is on the port now; hand back to SERVE.
                        state_q <= SERVE;
                        busy_q  <= 1'b0;
                    end else if (addr_x_p1 == X_LAST) begin
                        vld_p1    <= 1'b1;
                        addr_x_p1 <= '0;
                        addr_y_p1 <= addr_y_p1 + 1'b1;
                    end else begin
                        vld_p1    <= 1'b1;
                        addr_x_p1 <= addr_x_p1 + 1'b1;
                    end
                end
                default: state_q <= SERVE;
            endcase
        end
    end

    assign we_o     = vld_p1;
    assign err_o    = err_p1;
    assign busy_o   = busy_q;
    assign addr_x_o = addr_x_p1;
    assign addr_y_o = addr_y_p1;
    assign color_o  = color_p1;

endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_write_arbiter
//
// Directed bench. Instance dut_a uses the full 1280x1024 frame for the
// arbitration and range checks; instance dut_b uses a 4x3 frame so the
// clear sequence can be followed pixel by pixel.
// ---------------------------------------------------------------------------
module tb_vga_fb_write_arbiter;

    logic clk = 1'b0;
    logic arst;

    always #5 clk = ~clk;

    // dut_a: default geometry
    logic [1:0]  a_valid;
    logic [1:0]  a_ready;
    logic [21:0] a_x, a_y;
    logic [3:0]  a_col;
    logic        a_clear;
    logic [1:0]  a_ccol;
    logic        a_busy, a_err, a_we;
    logic [10:0] a_ax, a_ay;
    logic [1:0]  a_color;

    // dut_b: 4x3 frame
    logic [1:0]  b_valid;
    logic [1:0]  b_ready;
    logic [21:0] b_x, b_y;
    logic [3:0]  b_col;
    logic        b_clear;
    logic [1:0]  b_ccol;
    logic        b_busy, b_err, b_we;
    logic [10:0] b_ax, b_ay;
    logic [1:0]  b_color;

    vga_fb_write_arbiter #(.NREQ(2), .HD(1280), .VD(1024), .ADDR_BITS(11)) dut_a (
        .clk(clk), .arst(arst),
        .req_valid_i(a_valid), .req_ready_o(a_ready),
        .req_x_i(a_x), .req_y_i(a_y), .req_color_i(a_col),
        .clear_i(a_clear), .clear_color_i(a_ccol),
        .busy_o(a_busy), .err_o(a_err), .we_o(a_we),
        .addr_x_o(a_ax), .addr_y_o(a_ay), .color_o(a_color)
    );

    vga_fb_write_arbiter #(.NREQ(2), .HD(4), .VD(3), .ADDR_BITS(11)) dut_b (
        .clk(clk), .arst(arst),
        .req_valid_i(b_valid), .req_ready_o(b_ready),
        .req_x_i(b_x), .req_y_i(b_y), .req_color_i(b_col),
        .clear_i(b_clear), .clear_color_i(b_ccol),
        .busy_o(b_busy), .err_o(b_err), .we_o(b_we),
        .addr_x_o(b_ax), .addr_y_o(b_ay), .color_o(b_color)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check a full 12-pixel clear on dut_b; optionally pulse clear_i again
    // at write index repulse (negative = no pulse).
    task automatic run_clear_b(input logic [1:0] colour, input int repulse);
        for (int k = 0; k < 12; k++) begin
            chk("clr_we",    32'(b_we),    32'd1);
            chk("clr_busy",  32'(b_busy),  32'd1);
            chk("clr_x",     32'(b_ax),    32'(k % 4));
            chk("clr_y",     32'(b_ay),    32'(k / 4));
            chk("clr_color", 32'(b_color), 32'(colour));
            chk("clr_ready", 32'(b_ready), 32'd0);
            b_clear = (k == repulse);
            tick();
        end
        b_clear = 1'b0;
    endtask

    initial begin
        arst    = 1'b1;
        a_valid = 2'b11; a_x = '0; a_y = '0; a_col = '0; a_clear = 1'b0; a_ccol = '0;
        b_valid = 2'b00; b_x = '0; b_y = '0; b_col = '0; b_clear = 1'b0; b_ccol = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state, with requests pending on dut_a
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_we",    32'(a_we),    32'd0);
        chk("rst_err",   32'(a_err),   32'd0);
        chk("rst_busy",  32'(a_busy),  32'd0);
        chk("rst_x",     32'(a_ax),    32'd0);
        chk("rst_y",     32'(a_ay),    32'd0);
        chk("rst_color", 32'(a_color), 32'd0);

        @(negedge clk);
        arst    = 1'b0;
        a_valid = 2'b00;
        tick();

        // T1: single write from requester 0
        a_x = {11'd0, 11'd5}; a_y = {11'd0, 11'd7}; a_col = {2'd0, 2'd2};
        a_valid = 2'b01;
        #1;
        chk("t1_ready", 32'(a_ready), 32'b01);
        tick();
        chk("t1_we",    32'(a_we),    32'd1);
        chk("t1_x",     32'(a_ax),    32'd5);
        chk("t1_y",     32'(a_ay),    32'd7);
        chk("t1_color", 32'(a_color), 32'd2);
        a_valid = 2'b00;
        tick();
        chk("t1_idle_we",  32'(a_we), 32'd0);
        chk("t1_hold_x",   32'(a_ax), 32'd5);

        // T3: requester 1 out of range (pointer is at 1 after T1)
        a_x = {11'd1280, 11'd0}; a_y = {11'd0, 11'd0}; a_col = {2'd1, 2'd0};
        a_valid = 2'b10;
        #1;
        chk("t3_ready", 32'(a_ready), 32'b10);
        tick();
        chk("t3_we",  32'(a_we),  32'd0);
        chk("t3_err", 32'(a_err), 32'd1);
        chk("t3_x",   32'(a_ax),  32'd5);
        chk("t3_y",   32'(a_ay),  32'd7);
        a_valid = 2'b00;
        tick();
        chk("t3_err_pulse", 32'(a_err), 32'd0);

        // T2: both valid for 6 cycles, pointer back at 0
        a_x = {11'd30, 11'd20}; a_y = {11'd2, 11'd1}; a_col = {2'd1, 2'd3};
        a_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t2_ready", 32'(a_ready), (i % 2 == 0) ? 32'b01 : 32'b10);
            tick();
            chk("t2_we",    32'(a_we),    32'd1);
            chk("t2_x",     32'(a_ax),    (i % 2 == 0) ? 32'd20 : 32'd30);
            chk("t2_y",     32'(a_ay),    (i % 2 == 0) ? 32'd1  : 32'd2);
            chk("t2_color", 32'(a_color), (i % 2 == 0) ? 32'd3  : 32'd1);
        end
        a_valid = 2'b00;
        tick();
        chk("t2_end_we", 32'(a_we), 32'd0);

        // T4: clear wins over a simultaneous request, then req0 is served
        b_x = {11'd0, 11'd1}; b_y = {11'd0, 11'd1}; b_col = {2'd0, 2'd2};
        b_valid = 2'b01;
        b_clear = 1'b1; b_ccol = 2'd1;
        #1;
        chk("t4_ready_blocked", 32'(b_ready), 32'd0);
        chk("t4_busy_pre",      32'(b_busy),  32'd0);
        tick();
        b_clear = 1'b0;
        run_clear_b(2'd1, -1);
        chk("t4_busy_drop", 32'(b_busy),  32'd0);
        chk("t4_we_drop",   32'(b_we),    32'd0);
        chk("t4_ready0",    32'(b_ready), 32'b01);
        tick();
        chk("t4_req_we",    32'(b_we),    32'd1);
        chk("t4_req_x",     32'(b_ax),    32'd1);
        chk("t4_req_y",     32'(b_ay),    32'd1);
        chk("t4_req_color", 32'(b_color), 32'd2);
        b_valid = 2'b00;
        tick();

        // T5: clear_i pulsed mid-clear must not restart the sequence
        b_clear = 1'b1; b_ccol = 2'd3;
        tick();
        b_clear = 1'b0;
        run_clear_b(2'd3, 4);
        chk("t5_busy_drop", 32'(b_busy), 32'd0);
        chk("t5_we_drop",   32'(b_we),   32'd0);
        tick();
        chk("t5_no_restart_we",   32'(b_we),   32'd0);
        chk("t5_no_restart_busy", 32'(b_busy), 32'd0);

        // T6: reset at write 5 of a clear (dut_b pointer is 1 beforehand)
        b_clear = 1'b1; b_ccol = 2'd2;
        tick();
        b_clear = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("t6_pre_x",    32'(b_ax),   32'd1);
        chk("t6_pre_y",    32'(b_ay),   32'd1);
        chk("t6_pre_busy", 32'(b_busy), 32'd1);
        arst = 1'b1;
        #1;
        chk("t6_rst_we",    32'(b_we),    32'd0);
        chk("t6_rst_busy",  32'(b_busy),  32'd0);
        chk("t6_rst_x",     32'(b_ax),    32'd0);
        chk("t6_rst_y",     32'(b_ay),    32'd0);
        chk("t6_rst_color", 32'(b_color), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        tick();
        chk("t6_idle_we",   32'(b_we),   32'd0);
        chk("t6_idle_busy", 32'(b_busy), 32'd0);
        b_x = {11'd3, 11'd2}; b_y = {11'd2, 11'd0}; b_col = {2'd1, 2'd3};
        b_valid = 2'b11;
        #1;
        chk("t6_ptr0_ready", 32'(b_ready), 32'b01);
        tick();
        chk("t6_we",    32'(b_we),    32'd1);
        chk("t6_x",     32'(b_ax),    32'd2);
        chk("t6_y",     32'(b_ay),    32'd0);
        chk("t6_color", 32'(b_color), 32'd3);
        chk("t6_ready1", 32'(b_ready), 32'b10);
        tick();
        chk("t6_we2", 32'(b_we), 32'd1);
        chk("t6_x2",  32'(b_ax), 32'd3);
        chk("t6_y2",  32'(b_ay), 32'd2);
        b_valid = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
